// File: rtl/urna_apuracao.sv
// Vote tally for the voting machine: synchronises the pushbuttons, classifies confirmed numbers, keeps
// saturating BCD tallies, holds a post-vote lockout and drives two 7-segment digits. Optional: URNA_ENCERRA_EN.
module urna_apuracao #(
   parameter logic [7:0] CAND0    = 8'h13,
   parameter logic [7:0] CAND1    = 8'h45,
   parameter logic [7:0] CAND2    = 8'h17,
   parameter logic [7:0] CAND3    = 8'h22,
   parameter int         LOCK_CYC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd2,
   input  logic       key_conf,
   input  logic       key_branco,
`ifdef URNA_ENCERRA_EN
   input  logic       key_fim,
`endif
   input  logic [2:0] sel,
   output logic       voto_ok,
   output logic       busy,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [1:0] estado
);

   localparam int LW = (LOCK_CYC > 2) ? $clog2(LOCK_CYC) : 1;

   typedef enum logic [1:0] {ESPERA = 2'd0, GRAVA = 2'd1, TRAVA = 2'd2} state_t;

   state_t        state, state_d;
   logic [LW-1:0] lock, lock_d;
   logic [2:0]    kind, kind_d, kind_cls;
   logic [7:0]    cnt [0:6];
   logic [7:0]    shown;
   logic [2:0]    sc, sb;
   logic          conf_stb, branco_stb, encerrada;

   // bit0/bit1 are the synchroniser, bit2 holds the previous synchronised level for edge detection
   always_ff @(posedge clk) begin
      if (!rst) begin
         sc <= 3'b111;
         sb <= 3'b111;
      end else begin
         sc <= {sc[1:0], key_conf};
         sb <= {sb[1:0], key_branco};
      end
   end

   assign conf_stb   = sc[2] & ~sc[1];
   assign branco_stb = sb[2] & ~sb[1];

`ifdef URNA_ENCERRA_EN
   logic [2:0] sf;
   logic       fim_stb;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sf        <= 3'b111;
         encerrada <= 1'b0;
      end else begin
         sf <= {sf[1:0], key_fim};
         if (fim_stb && state != GRAVA) encerrada <= 1'b1;
      end
   end

   assign fim_stb = sf[2] & ~sf[1];
`else
   assign encerrada = 1'b0;
`endif

   // kind encoding: 0-3 candidates, 4 blank, 5 null (also the tally index)
   always_comb begin
      kind_cls = 3'd5;
      if      ({bcd1, bcd2} == CAND0) kind_cls = 3'd0;
      else if ({bcd1, bcd2} == CAND1) kind_cls = 3'd1;
      else if ({bcd1, bcd2} == CAND2) kind_cls = 3'd2;
      else if ({bcd1, bcd2} == CAND3) kind_cls = 3'd3;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ESPERA;
         lock  <= '0;
         kind  <= 3'd0;
      end else begin
         state <= state_d;
         lock  <= lock_d;
         kind  <= kind_d;
      end
   end

   always_comb begin
      state_d = state;
      lock_d  = lock;
      kind_d  = kind;
      case (state)
         ESPERA: begin
            if (!encerrada) begin
               if (branco_stb) begin
                  kind_d  = 3'd4;
                  state_d = GRAVA;
               end else if (conf_stb) begin
                  kind_d  = kind_cls;
                  state_d = GRAVA;
               end
            end
         end
         GRAVA: begin
            lock_d  = LW'(LOCK_CYC - 1);
            state_d = TRAVA;
         end
         TRAVA: begin
            if (lock == '0) state_d = ESPERA;
            else            lock_d  = lock - LW'(1);
         end
         default: state_d = ESPERA;
      endcase
   end

   assign voto_ok = (state == GRAVA);
   assign busy    = (state == TRAVA) | encerrada;
   assign estado  = state;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == 8'h99)            return v;
      else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
      else                       return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // index 6 is the running total of all recorded votes
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 7; i++) cnt[i] <= 8'h00;
      end else if (state == GRAVA) begin
         cnt[kind] <= bcd_inc(cnt[kind]);
         cnt[6]    <= bcd_inc(cnt[6]);
      end
   end

   always_comb begin
      shown = cnt[6];
      case (sel)
         3'd0: shown = cnt[0];
         3'd1: shown = cnt[1];
         3'd2: shown = cnt[2];
         3'd3: shown = cnt[3];
         3'd4: shown = cnt[4];
         3'd5: shown = cnt[5];
         default: shown = cnt[6];
      endcase
   end

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   assign hex1 = seg(shown[3:0]);
   assign hex2 = seg(shown[7:4]);

endmodule

// File: tb/tb_urna_apuracao.sv
// Directed bench for urna_apuracao: votes of every kind, lockout length, key masking, saturation and resets.
module tb_urna_apuracao;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] bcd1, bcd2;
   logic       key_conf, key_branco;
   logic [2:0] sel;
   logic       voto_ok, busy;
   logic [6:0] hex1, hex2;
   logic [1:0] estado;
`ifdef URNA_ENCERRA_EN
   logic       key_fim = 1'b1;
`endif

   int total = 0;
   int bad   = 0;
   int seen, blen;

   urna_apuracao dut (
      .clk(clk), .rst(rst), .bcd1(bcd1), .bcd2(bcd2),
      .key_conf(key_conf), .key_branco(key_branco),
`ifdef URNA_ENCERRA_EN
      .key_fim(key_fim),
`endif
      .sel(sel), .voto_ok(voto_ok), .busy(busy),
      .hex1(hex1), .hex2(hex2), .estado(estado)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_tally(input string tag, input logic [2:0] s, input int v);
      sel = s;
      #1;
      chk(tag, {2'b00, hex2, hex1}, {2'b00, seg7(v / 10), seg7(v % 10)});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // press (0 = pressed) for a few cycles, then count voto_ok pulses and busy cycles until the lockout ends
   task automatic vote(input logic c, input logic b, output int n_ok, output int n_busy);
      n_ok = 0;
      n_busy = 0;
      key_conf = c;
      key_branco = b;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (voto_ok) n_ok++;
         if (busy) n_busy++;
      end
      key_conf = 1'b1;
      key_branco = 1'b1;
      for (int i = 0; i < 40 && busy; i++) begin
         @(negedge clk);
         if (voto_ok) n_ok++;
         if (busy) n_busy++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_voto(input string tag);
      int hit;
      hit = 0;
      for (int i = 0; i < 10 && hit == 0; i++) begin
         @(negedge clk);
         if (voto_ok) hit = 1;
      end
      chk(tag, 16'(hit), 16'd1);
   endtask

   initial begin
      rst = 1'b0; bcd1 = 4'd0; bcd2 = 4'd0;
      key_conf = 1'b1; key_branco = 1'b1; sel = 3'd6;
      repeat (3) @(negedge clk);
      chk_tally("rst_total", 3'd6, 0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_voto", 16'(voto_ok), 16'd0);
      rst = 1'b1;
      @(negedge clk);

      bcd1 = 4'd4; bcd2 = 4'd5;
      vote(1'b0, 1'b1, seen, blen);
      chk("c1_pulse", 16'(seen), 16'd1);
      chk("c1_busy_len", 16'(blen), 16'd16);
      chk_tally("c1_tally", 3'd1, 1);
      chk_tally("c1_total", 3'd6, 1);
      chk_tally("c1_c0", 3'd0, 0);

      bcd1 = 4'd9; bcd2 = 4'd9;
      vote(1'b0, 1'b1, seen, blen);
      chk_tally("nulo99", 3'd5, 1);
      bcd1 = 4'hA; bcd2 = 4'd3;
      vote(1'b0, 1'b1, seen, blen);
      chk("nuloA3_pulse", 16'(seen), 16'd1);
      chk_tally("nuloA3", 3'd5, 2);
      chk_tally("nulo_c1", 3'd1, 1);
      chk_tally("nulo_c0", 3'd0, 0);
      bcd1 = 4'd2; bcd2 = 4'd2;
      vote(1'b0, 1'b1, seen, blen);
      chk_tally("c3_tally", 3'd3, 1);
      chk_tally("c3_total", 3'd7, 4);
      chk_tally("branco_zero", 3'd4, 0);

      do_reset();
      bcd1 = 4'd4; bcd2 = 4'd5;
      vote(1'b0, 1'b0, seen, blen);
      chk("both_pulse", 16'(seen), 16'd1);
      chk_tally("both_branco", 3'd4, 1);
      chk_tally("both_nulo", 3'd5, 0);
      chk_tally("both_c1", 3'd1, 0);
      chk_tally("both_total", 3'd6, 1);

      key_conf = 1'b0;
      wait_voto("lock_first");
      repeat (3) @(negedge clk);
      key_conf = 1'b1;
      @(negedge clk);
      key_conf = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (voto_ok) seen++;
      end
      key_conf = 1'b1;
      repeat (3) @(negedge clk);
      chk("lock_ignored", 16'(seen), 16'd0);
      chk("lock_busy_end", 16'(busy), 16'd0);
      chk_tally("lock_c1", 3'd1, 1);
      chk_tally("lock_total", 3'd6, 2);

      do_reset();
      bcd1 = 4'd1; bcd2 = 4'd3;
      for (int i = 0; i < 101; i++) vote(1'b0, 1'b1, seen, blen);
      chk_tally("sat_c0", 3'd0, 99);
      chk_tally("sat_total", 3'd6, 99);

      key_conf = 1'b0;
      wait_voto("mid_vote");
      repeat (4) @(negedge clk);
      key_conf = 1'b1;
      chk("mid_busy_before", 16'(busy), 16'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_busy", 16'(busy), 16'd0);
      chk("mid_voto", 16'(voto_ok), 16'd0);
      rst = 1'b1;
      chk_tally("mid_c0", 3'd0, 0);
      chk_tally("mid_total", 3'd6, 0);
      @(negedge clk);

`ifdef URNA_ENCERRA_EN
      key_fim = 1'b0;
      repeat (6) @(negedge clk);
      key_fim = 1'b1;
      chk("fim_busy", 16'(busy), 16'd1);
      vote(1'b0, 1'b1, seen, blen);
      chk("fim_no_vote", 16'(seen), 16'd0);
      chk("fim_busy_after", 16'(busy), 16'd1);
      chk_tally("fim_total", 3'd6, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
